sequence_generator: RTL and testbench



---
 rtl/sequence_generator.sv | 134 +++++++++++++
 tb/tb_sequence_generator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter, MSB first, DIV clocks/bit.
// Ports: CLOCK_50 clk, rst sync active-low, start/repeat_cnt in;
//   tx_bit, tx_strobe, busy, done, bit_index, diods (last 10 bits) out.
// Build option: define SEQGEN_GAP_EN to insert a strobed '0' bit
//   period between consecutive pattern repetitions.
module sequence_generator #(
    parameter int                   PATTERN_W = 7,
    parameter logic [PATTERN_W-1:0] PATTERN   = 7'b1100110,
    parameter int                   DIV       = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] repeat_cnt,
    output logic       tx_bit,
    output logic       tx_strobe,
    output logic       busy,
    output logic       done,
    output logic [3:0] bit_index,
    output logic [9:0] diods
);

    localparam int              DW      = $clog2(DIV);
    localparam logic [DW-1:0]   DLAST   = DW'(DIV - 1);
    localparam logic [3:0]      IDX_TOP = 4'(PATTERN_W - 1);
    // Zero-padded copy so a 4-bit index never exceeds the vector.
    localparam logic [15:0]     PAT16   = 16'(PATTERN);

`ifdef SEQGEN_GAP_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [3:0]    reps, reps_n;
    logic [3:0]    idx_n;
    logic          bit_n;
    logic [9:0]    diods_n;
    logic          last_clk;

    assign last_clk = (div_cnt == DLAST);

    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            reps      <= '0;
            bit_index <= '0;
            tx_bit    <= 1'b0;
            diods     <= '0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            reps      <= reps_n;
            bit_index <= idx_n;
            tx_bit    <= bit_n;
            diods     <= diods_n;
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        reps_n    = reps;
        idx_n     = bit_index;
        bit_n     = tx_bit;
        diods_n   = diods;
        tx_strobe = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                    reps_n  = (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
                    idx_n   = IDX_TOP;
                    bit_n   = PAT16[IDX_TOP];
                    div_n   = '0;
                    diods_n = '0;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                tx_strobe = last_clk;
                if (last_clk) begin
                    div_n   = '0;
                    diods_n = {diods[8:0], tx_bit};
                    if (bit_index != 4'd0) begin
                        idx_n = bit_index - 4'd1;
                        bit_n = PAT16[bit_index - 4'd1];
                    end else if (reps > 4'd1) begin
                        reps_n = reps - 4'd1;
`ifdef SEQGEN_GAP_EN
                        state_n = GAP;
                        bit_n   = 1'b0;
`else
                        idx_n = IDX_TOP;
                        bit_n = PAT16[IDX_TOP];
`endif
                    end else begin
                        state_n = DONE;
                        bit_n   = 1'b0;
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
`ifdef SEQGEN_GAP_EN
            GAP: begin
                busy      = 1'b1;
                tx_strobe = last_clk;
                if (last_clk) begin
                    div_n   = '0;
                    diods_n = {diods[8:0], tx_bit};
                    state_n = SHIFT;
                    idx_n   = IDX_TOP;
                    bit_n   = PAT16[IDX_TOP];
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                bit_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Testbench for sequence_generator (DIV=4, default pattern).
// Timeline model plus directed literal checks.
module tb_sequence_generator;

    localparam int         PW  = 7;
    localparam int         DIV = 4;
    localparam logic [6:0] PAT = 7'b1100110;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] repeat_cnt = 4'd0;
    logic       tx_bit, tx_strobe, busy, done;
    logic [3:0] bit_index;
    logic [9:0] diods;

    sequence_generator #(.DIV(DIV)) dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .start     (start),
        .repeat_cnt(repeat_cnt),
        .tx_bit    (tx_bit),
        .tx_strobe (tx_strobe),
        .busy      (busy),
        .done      (done),
        .bit_index (bit_index),
        .diods     (diods)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Model: a transmission is the list of bits to send; cycle k of
    // the busy window carries bit k/DIV and strobes on k%DIV==DIV-1.
    int         ph = 0;
    int         k = 0;
    bit         seq[$];
    int         idxq[$];
    logic [9:0] m_diods = '0;

    task automatic build(input logic [3:0] rc);
        int r;
        r = (rc == 4'd0) ? 1 : int'(rc);
        seq.delete();
        idxq.delete();
        for (int i = 0; i < r; i++) begin
`ifdef SEQGEN_GAP_EN
            if (i > 0) begin
                seq.push_back(1'b0);
                idxq.push_back(0);
            end
`endif
            for (int b = PW - 1; b >= 0; b--) begin
                seq.push_back(PAT[b]);
                idxq.push_back(b);
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            ph = 0;
            k = 0;
            m_diods = '0;
        end else begin
            case (ph)
                0: if (start) begin
                    build(repeat_cnt);
                    ph = 1;
                    k = 0;
                    m_diods = '0;
                end
                1: begin
                    if (k % DIV == DIV - 1)
                        m_diods = {m_diods[8:0], seq[k / DIV]};
                    k++;
                    if (k == seq.size() * DIV) ph = 2;
                end
                default: ph = 0;
            endcase
        end
    end

    // Observation counters
    int         cyc = 0;
    int         busy_cnt, strb_cnt, done_cnt;
    int         done_cyc, last_strb_cyc, rise_cyc, det_hit;
    logic [15:0] bits;
    logic [6:0] det;
    logic       prev_busy = 1'b0;

    task automatic clr();
        busy_cnt = 0;
        strb_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        last_strb_cyc = -1;
        rise_cyc = -1;
        det_hit = 0;
        bits = '0;
        det = '0;
    endtask

    always @(negedge clk) begin
        int e_bit, e_stb, e_busy, e_done, e_idx;
        cyc++;
        e_bit = 0; e_stb = 0; e_busy = 0; e_done = 0; e_idx = 0;
        if (ph == 1) begin
            e_bit  = seq[k / DIV];
            e_stb  = (k % DIV == DIV - 1) ? 1 : 0;
            e_busy = 1;
            e_idx  = idxq[k / DIV];
        end else if (ph == 2) begin
            e_done = 1;
        end
        chk("tx_bit", tx_bit, e_bit);
        chk("tx_strobe", tx_strobe, e_stb);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("bit_index", bit_index, e_idx);
        chk("diods", diods, m_diods);
        if (busy) busy_cnt++;
        if (busy && !prev_busy) rise_cyc = cyc;
        prev_busy = busy;
        if (tx_strobe) begin
            strb_cnt++;
            last_strb_cyc = cyc;
            bits = {bits[14:0], tx_bit};
            det = {det[5:0], tx_bit};
            if (det == PAT && det_hit == 0) det_hit = strb_cnt;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("done_timeout", done_cnt, target);
    endtask

    task automatic xfer(input logic [3:0] rc, input bit mid);
        clr();
        @(negedge clk); #1;
        repeat_cnt = rc;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("first_idx", bit_index, PW - 1);
        chk("first_busy", busy, 1);
        if (mid) begin
            repeat (10) @(negedge clk);
            #1 start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
        end
        wait_done(1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        int t;
        clr();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_diods", diods, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        xfer(4'd1, 1'b0);
        chk("r1_strobes", strb_cnt, 7);
        chk("r1_bits", bits[6:0], 7'b1100110);
        chk("r1_busy_cyc", busy_cnt, 28);
        chk("r1_done_cnt", done_cnt, 1);
        chk("r1_done_lag", done_cyc - last_strb_cyc, 1);
        chk("r1_diods", diods, 10'b0001100110);
        chk("detector_hit", det_hit, 7);

        xfer(4'd0, 1'b0);
        chk("r0_strobes", strb_cnt, 7);
        chk("r0_busy_cyc", busy_cnt, 28);
        chk("r0_done_cnt", done_cnt, 1);

        xfer(4'd2, 1'b0);
`ifdef SEQGEN_GAP_EN
        chk("r2_strobes", strb_cnt, 15);
        chk("r2_bits", bits[14:0], 15'b110011001100110);
        chk("r2_busy_cyc", busy_cnt, 60);
        chk("r2_diods", diods, 10'b1001100110);
`else
        chk("r2_strobes", strb_cnt, 14);
        chk("r2_bits", bits[13:0], 14'b11001101100110);
        chk("r2_busy_cyc", busy_cnt, 56);
        chk("r2_diods", diods, 10'b1101100110);
`endif

        xfer(4'd1, 1'b1);
        chk("mid_strobes", strb_cnt, 7);
        chk("mid_busy_cyc", busy_cnt, 28);
        chk("mid_done_lag", done_cyc - last_strb_cyc, 1);

        // start held high: one idle cycle between done and next busy
        clr();
        @(negedge clk); #1;
        repeat_cnt = 4'd1;
        start = 1'b1;
        wait_done(1);
        t = done_cyc;
        rise_cyc = -1;
        repeat (3) @(negedge clk);
        #1 start = 1'b0;
        chk("held_restart", rise_cyc - t, 2);
        wait_done(2);
        chk("held_strobes", strb_cnt, 14);
        repeat (2) @(negedge clk);
        #1;

        // reset during the 4th bit's strobe cycle
        clr();
        repeat_cnt = 4'd1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!(ph == 1 && k == 4 * DIV - 1) && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("rst_reach", tx_strobe, 1);
        chk("rst_4th_cnt", strb_cnt, 4);
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        chk("rstm_busy", busy, 0);
        chk("rstm_bit", tx_bit, 0);
        chk("rstm_idx", bit_index, 0);
        chk("rstm_diods", diods, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("rstm_no_done", done_cnt, 0);

        xfer(4'd1, 1'b0);
        chk("post_rst_strobes", strb_cnt, 7);
        chk("post_rst_diods", diods, 10'b0001100110);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
